// File: rtl/icache_dm_burst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_dm_burst_pkg : shared widths and FSM codes for the I-cache     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package icache_dm_burst_pkg;

  localparam int AddressWidth = 32;
  localparam int IDWidth      = 32;

  typedef enum logic [0:0] {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icache_state_e;

endpackage
`default_nettype wire

// File: rtl/icache_dm_burst_line_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_dm_burst_line_bank : line data store, 1 sync write, 1 comb rd  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module icache_dm_burst_line_bank #(
  parameter int INDEX_WIDTH = 6,
  parameter int WORD_SEL_W  = 2,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic [WORD_SEL_W-1:0]  wr_word,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  input  logic [WORD_SEL_W-1:0]  rd_word,
  output logic [DATA_W-1:0]      rd_data
);

  localparam int DEPTH = (1 << INDEX_WIDTH) * (1 << WORD_SEL_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_idx, wr_word}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_idx, rd_word}];

endmodule
`default_nettype wire

// File: rtl/icache_dm_burst.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | icache_dm_burst : direct-mapped I-cache, whole-line burst refill      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module icache_dm_burst
  import icache_dm_burst_pkg::*;
#(
  parameter int ADDR_WIDTH  = AddressWidth,
  parameter int INDEX_WIDTH = 6,
  parameter int WORD_SEL_W  = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  if_icache_en_in,
  input  logic [ADDR_WIDTH-1:0] if_icache_addr_in,
  output logic                  icache_if_hit_out,
  output logic [IDWidth-1:0]    icache_if_inst_out,
  output logic                  icache_ramctrl_en_out,
  output logic [ADDR_WIDTH-1:0] icache_ramctrl_addr_out,
  input  logic                  ramctrl_icache_rdy_in,
  input  logic [IDWidth-1:0]    ramctrl_icache_data_in
);

  localparam int TAG_W      = ADDR_WIDTH - INDEX_WIDTH - WORD_SEL_W - 2;
  localparam int LINE_WORDS = 1 << WORD_SEL_W;
  localparam int LINE_COUNT = 1 << INDEX_WIDTH;

  icache_state_e             state, state_next;
  logic [LINE_COUNT-1:0]     valid;
  logic [TAG_W-1:0]          tags [LINE_COUNT];
  logic [TAG_W-1:0]          base_tag;
  logic [INDEX_WIDTH-1:0]    base_idx;
  logic [WORD_SEL_W-1:0]     cnt;

  logic [TAG_W-1:0]          req_tag;
  logic [INDEX_WIDTH-1:0]    req_idx;
  logic [WORD_SEL_W-1:0]     req_word;
  logic                      byte_off_unused;
  logic                      hit;
  logic                      last_word;
  logic                      start_refill;
  logic                      finish_refill;
  logic                      word_we;

  assign req_tag         = if_icache_addr_in[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx         = if_icache_addr_in[WORD_SEL_W+2 +: INDEX_WIDTH];
  assign req_word        = if_icache_addr_in[2 +: WORD_SEL_W];
  assign byte_off_unused = ^if_icache_addr_in[1:0];

  assign hit = (state == ICACHE_IDLE) & if_icache_en_in & valid[req_idx] &
               (tags[req_idx] == req_tag) & ~flush_in;
  assign last_word = (cnt == WORD_SEL_W'(LINE_WORDS - 1));

  always_comb begin
    state_next    = state;
    start_refill  = 1'b0;
    finish_refill = 1'b0;
    word_we       = 1'b0;
    case (state)
      ICACHE_IDLE: begin
        if (if_icache_en_in && !hit && !flush_in) begin
          start_refill = 1'b1;
          state_next   = ICACHE_REFILL;
        end
      end
      ICACHE_REFILL: begin
        // Flush wins over a coincident data pulse: the word is dropped.
        if (flush_in) begin
          state_next = ICACHE_IDLE;
        end else if (ramctrl_icache_rdy_in) begin
          word_we = 1'b1;
          if (last_word) begin
            finish_refill = 1'b1;
            state_next    = ICACHE_IDLE;
          end
        end
      end
      default: state_next = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= ICACHE_IDLE;
      valid    <= '0;
      cnt      <= '0;
      base_tag <= '0;
      base_idx <= '0;
    end else if (rdy_in) begin
      state <= state_next;
      if (flush_in) begin
        valid <= '0;
        cnt   <= '0;
      end else if (start_refill) begin
        valid[req_idx] <= 1'b0;
        base_tag       <= req_tag;
        base_idx       <= req_idx;
        cnt            <= '0;
      end else if (word_we) begin
        cnt <= cnt + 1'b1;
        if (finish_refill) begin
          valid[base_idx] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && finish_refill) begin
      tags[base_idx] <= base_tag;
    end
  end

  icache_dm_burst_line_bank #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .WORD_SEL_W  (WORD_SEL_W),
    .DATA_W      (IDWidth)
  ) u_line_bank (
    .clk     (clk_in),
    .we      (word_we & rdy_in & ~rst_in),
    .wr_idx  (base_idx),
    .wr_word (cnt),
    .wr_data (ramctrl_icache_data_in),
    .rd_idx  (req_idx),
    .rd_word (req_word),
    .rd_data (icache_if_inst_out)
  );

  assign icache_if_hit_out       = hit;
  assign icache_ramctrl_en_out   = (state == ICACHE_REFILL);
  assign icache_ramctrl_addr_out = (state == ICACHE_REFILL) ?
                                   {base_tag, base_idx, cnt, 2'b00} : '0;

endmodule
`default_nettype wire

// File: tb/tb_icache_dm_burst.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_icache_dm_burst : directed + random bench with line-level model    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_icache_dm_burst;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush_in, if_en, rrdy;
  logic [31:0] if_addr, rdata;
  logic        hit, ren;
  logic [31:0] inst, raddr;

  always #5 clk = ~clk;

  icache_dm_burst dut (
    .clk_in                  (clk),
    .rst_in                  (rst_in),
    .rdy_in                  (rdy_in),
    .flush_in                (flush_in),
    .if_icache_en_in         (if_en),
    .if_icache_addr_in       (if_addr),
    .icache_if_hit_out       (hit),
    .icache_if_inst_out      (inst),
    .icache_ramctrl_en_out   (ren),
    .icache_ramctrl_addr_out (raddr),
    .ramctrl_icache_rdy_in   (rrdy),
    .ramctrl_icache_data_in  (rdata)
  );

  // Model: which 16-byte line (addr>>4) is resident in each slot, plus the
  // line currently being fetched and how many of its words have arrived.
  bit          m_valid [64];
  logic [27:0] m_line  [64];
  bit          m_pend;
  logic [27:0] m_base;
  int          m_done;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  bit          chk_on = 0;
  logic [31:0] cap_q [$];
  logic        obs_hit, obs_ren;
  logic [31:0] obs_inst, obs_raddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
  endfunction

  function automatic bit model_hit(input logic en, input logic [31:0] a, input logic fl);
    int idx;
    idx = int'((a >> 4) % 64);
    return !m_pend && en && !fl && m_valid[idx] && (m_line[idx] == a[31:4]);
  endfunction

  function automatic logic [31:0] model_raddr();
    return {m_base, 4'h0} + 32'(4 * m_done);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
    m_pend = 0;
    m_done = 0;
  endtask

  task automatic step(input logic en, input logic [31:0] a, input logic fl,
                      input logic rdy, input logic rs, input logic want_rr);
    bit e_hit;
    @(negedge clk);
    rst_in   = rs;
    rdy_in   = rdy;
    flush_in = fl;
    if_en    = en;
    if_addr  = a;
    rrdy     = want_rr & rdy & ren;
    rdata    = m_pend ? mem_word(model_raddr()) : $urandom;
    #1;
    obs_hit = hit; obs_inst = inst; obs_ren = ren; obs_raddr = raddr;
    e_hit = model_hit(en, a, fl);
    if (chk_on) begin
      chk("hit", {31'd0, hit}, {31'd0, e_hit});
      if (e_hit) chk("inst", inst, mem_word(a));
      chk("ramctrl_en", {31'd0, ren}, {31'd0, m_pend});
      if (m_pend) chk("ramctrl_addr", raddr, model_raddr());
    end
    if (rrdy && !rs) cap_q.push_back(raddr);
    @(posedge clk);
    if (rs) begin
      model_clear();
    end else if (rdy) begin
      if (fl) begin
        model_clear();
      end else if (m_pend) begin
        if (rrdy) begin
          m_done++;
          if (m_done == 4) begin
            m_valid[int'(m_base % 64)] = 1;
            m_line[int'(m_base % 64)]  = m_base;
            m_pend = 0;
          end
        end
      end else if (en && !e_hit) begin
        m_pend = 1;
        m_base = a[31:4];
        m_done = 0;
        m_valid[int'((a >> 4) % 64)] = 0;
      end
    end
  endtask

  task automatic fetch(input logic [31:0] a, input int n_words);
    for (int i = 0; i < n_words; i++) step(1, a, 0, 1, 0, 1);
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; flush_in = 0; if_en = 0; if_addr = 0; rrdy = 0; rdata = 0;
    model_clear();
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    chk_on = 1;

    // reset state
    step(0, 0, 0, 1, 0, 0);
    chk("rst_hit", {31'd0, obs_hit}, 32'd0);
    chk("rst_ren", {31'd0, obs_ren}, 32'd0);
    chk("rst_raddr", obs_raddr, 32'h0);

    // 1: cold miss at 0x40
    cap_q.delete();
    step(1, 32'h44, 0, 1, 0, 0);
    chk("t1_miss", {31'd0, obs_hit}, 32'd0);
    fetch(32'h44, 4);
    chk("t1_ncap", cap_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t1_addr", (i < cap_q.size()) ? cap_q[i] : 32'hDEAD_BEEF, 32'h40 + 32'(4 * i));
    step(1, 32'h44, 0, 1, 0, 0);
    chk("t1_hit", {31'd0, obs_hit}, 32'd1);
    chk("t1_inst", obs_inst, mem_word(32'h44));

    // 2: same-line hit
    step(1, 32'h48, 0, 1, 0, 0);
    chk("t2_hit", {31'd0, obs_hit}, 32'd1);
    chk("t2_ren", {31'd0, obs_ren}, 32'd0);

    // 3: conflict miss
    cap_q.delete();
    step(1, 32'h440, 0, 1, 0, 0);
    chk("t3_miss", {31'd0, obs_hit}, 32'd0);
    fetch(32'h440, 4);
    chk("t3_first", (cap_q.size() > 0) ? cap_q[0] : 32'hDEAD_BEEF, 32'h440);
    step(1, 32'h440, 0, 1, 0, 0);
    chk("t3_hit", {31'd0, obs_hit}, 32'd1);
    step(1, 32'h40, 0, 1, 0, 0);
    chk("t3_evict", {31'd0, obs_hit}, 32'd0);

    // 4: flush after the 2nd word of the 0x40 refill
    fetch(32'h40, 2);
    step(1, 32'h40, 1, 1, 0, 0);
    cap_q.delete();
    step(1, 32'h40, 0, 1, 0, 0);
    chk("t4_ren_drop", {31'd0, obs_ren}, 32'd0);
    chk("t4_miss", {31'd0, obs_hit}, 32'd0);
    fetch(32'h40, 4);
    chk("t4_first", (cap_q.size() > 0) ? cap_q[0] : 32'hDEAD_BEEF, 32'h40);
    step(1, 32'h4C, 0, 1, 0, 0);
    chk("t4_hit", {31'd0, obs_hit}, 32'd1);

    // 5: flush coincident with last word
    step(1, 32'h80, 0, 1, 0, 0);
    fetch(32'h80, 3);
    step(1, 32'h80, 1, 1, 0, 1);
    step(1, 32'h80, 0, 1, 0, 0);
    chk("t5_miss", {31'd0, obs_hit}, 32'd0);
    fetch(32'h80, 4);

    // 6: stall mid-refill
    step(1, 32'hC4, 0, 1, 0, 0);
    fetch(32'hC4, 2);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'hC4, 0, 0, 0, 1);
      chk("t6_addr_hold", obs_raddr, 32'hC8);
    end
    fetch(32'hC4, 2);
    step(1, 32'hC4, 0, 1, 0, 0);
    chk("t6_hit", {31'd0, obs_hit}, 32'd1);
    chk("t6_inst", obs_inst, mem_word(32'hC4));

    // reset mid-refill
    step(1, 32'h100, 0, 1, 0, 0);
    fetch(32'h100, 1);
    step(1, 32'h100, 0, 1, 1, 0);
    step(0, 32'h100, 0, 1, 0, 0);
    chk("rst_mid_ren", {31'd0, obs_ren}, 32'd0);

    // randomized traffic over a small, conflict-heavy address pool
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = {20'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom), 2'd0};
      step(($urandom_range(0, 3) != 0), a,
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
